// File: rtl/pipeline_flow_controller.sv
// Stall/flush sequencer for the 5-stage core: hazard resolution, debug halt/step
// FSM and saturating stall/flush performance counters.
module pipeline_flow_controller #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ex_redirect_i,
  input  logic                  mem_busy_i,
  input  logic                  dbg_halt_req_i,
  input  logic                  dbg_step_req_i,
  input  logic                  dbg_resume_req_i,
  input  logic                  cnt_clr_i,
  output logic                  pc_we_o,
  output logic                  if_id_we_o,
  output logic                  id_ex_we_o,
  output logic                  ex_mem_we_o,
  output logic                  mem_wb_we_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_flush_o,
  output logic                  mem_wb_flush_o,
  output logic                  global_stall_o,
  output logic                  dbg_halted_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  typedef enum logic [1:0] {StRun, StHaltPend, StHalted, StStep} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_halted;
  logic w_stall_inc;
  logic w_flush_inc;

  // Load-use hazard; x0 is hardwired zero so it never creates a dependency.
  always_comb begin
    w_load_use = ex_mem_read_i && (ex_rd_addr_i != '0) &&
                 ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                  (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));
  end

  assign w_halted    = (r_state == StHalted);
  assign w_stall_inc = !w_halted && (mem_busy_i || w_load_use) && !ex_redirect_i;
  assign w_flush_inc = !w_halted && !mem_busy_i && ex_redirect_i;

  // Debug FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Debug FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun: begin
        if (dbg_halt_req_i) w_state_next = mem_busy_i ? StHaltPend : StHalted;
      end
      StHaltPend: begin
        if (!mem_busy_i) w_state_next = StHalted;
      end
      StHalted: begin
        if (dbg_resume_req_i)    w_state_next = StRun;
        else if (dbg_step_req_i) w_state_next = StStep;
      end
      StStep: begin
        // Stay until one productive (non-busy) cycle has gone through.
        if (!mem_busy_i) w_state_next = StHalted;
      end
      default: w_state_next = StRun;
    endcase
  end

  // Prioritised pipeline control: freeze > memory wait > redirect > load-use > run.
  always_comb begin
    pc_we_o        = 1'b1;
    if_id_we_o     = 1'b1;
    id_ex_we_o     = 1'b1;
    ex_mem_we_o    = 1'b1;
    mem_wb_we_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    global_stall_o = 1'b0;
    dbg_halted_o   = w_halted;
    if (w_halted) begin
      // Flushes stay low: a flush would override the stall inside the registers.
      global_stall_o = 1'b1;
      pc_we_o        = 1'b0;
      if_id_we_o     = 1'b0;
      id_ex_we_o     = 1'b0;
      ex_mem_we_o    = 1'b0;
      mem_wb_we_o    = 1'b0;
    end else if (mem_busy_i) begin
      pc_we_o     = 1'b0;
      if_id_we_o  = 1'b0;
      id_ex_we_o  = 1'b0;
      ex_mem_we_o = 1'b0;
      mem_wb_we_o = 1'b0;
    end else if (ex_redirect_i) begin
      // ID instruction is on the wrong path, so any load-use match is moot.
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (w_load_use) begin
      pc_we_o       = 1'b0;
      if_id_we_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_flow_controller.sv
// Directed bench for pipeline_flow_controller with hand-computed expectations.
module tb_pipeline_flow_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_busy;
  logic       dbg_halt_req, dbg_step_req, dbg_resume_req, cnt_clr;
  logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic       global_stall, dbg_halted;
  logic [15:0] stall_cnt, flush_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // {pc, ifid, idex, exmem, memwb we | ifid, idex, exmem, memwb flush | stall, halted}
  logic [10:0] ctl;
  assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                global_stall, dbg_halted};

  localparam logic [10:0] CtlRun    = 11'b11111_0000_00;
  localparam logic [10:0] CtlHold   = 11'b00000_0000_00;
  localparam logic [10:0] CtlLdUse  = 11'b00111_0100_00;
  localparam logic [10:0] CtlRedir  = 11'b11111_1100_00;
  localparam logic [10:0] CtlFrozen = 11'b00000_0000_11;

  always #5 clk = ~clk;

  pipeline_flow_controller #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs1_addr_i    (id_rs1_addr),
    .id_rs2_addr_i    (id_rs2_addr),
    .id_uses_rs1_i    (id_uses_rs1),
    .id_uses_rs2_i    (id_uses_rs2),
    .ex_mem_read_i    (ex_mem_read),
    .ex_rd_addr_i     (ex_rd_addr),
    .ex_redirect_i    (ex_redirect),
    .mem_busy_i       (mem_busy),
    .dbg_halt_req_i   (dbg_halt_req),
    .dbg_step_req_i   (dbg_step_req),
    .dbg_resume_req_i (dbg_resume_req),
    .cnt_clr_i        (cnt_clr),
    .pc_we_o          (pc_we),
    .if_id_we_o       (if_id_we),
    .id_ex_we_o       (id_ex_we),
    .ex_mem_we_o      (ex_mem_we),
    .mem_wb_we_o      (mem_wb_we),
    .if_id_flush_o    (if_id_flush),
    .id_ex_flush_o    (id_ex_flush),
    .ex_mem_flush_o   (ex_mem_flush),
    .mem_wb_flush_o   (mem_wb_flush),
    .global_stall_o   (global_stall),
    .dbg_halted_o     (dbg_halted),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_busy = 0; dbg_halt_req = 0; dbg_step_req = 0; dbg_resume_req = 0; cnt_clr = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("reset_ctl", 32'(ctl), 32'(CtlRun));
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);

    // Load-use on rs2.
    ex_mem_read = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_uses_rs2 = 1;
    #1 chk("load_use_ctl", 32'(ctl), 32'(CtlLdUse));
    tick();
    chk("load_use_stall_cnt", 32'(stall_cnt), 1);

    // x0 never hazards; unused operand never hazards.
    idle_inputs();
    ex_mem_read = 1; ex_rd_addr = 0; id_rs1_addr = 0; id_uses_rs1 = 1;
    #1 chk("x0_no_hazard", 32'(ctl), 32'(CtlRun));
    ex_rd_addr = 7; id_rs1_addr = 7; id_uses_rs1 = 0;
    #1 chk("unused_rs1_no_hazard", 32'(ctl), 32'(CtlRun));
    tick();
    chk("no_hazard_stall_cnt", 32'(stall_cnt), 1);

    // Redirect overrides load-use.
    idle_inputs();
    ex_mem_read = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_uses_rs2 = 1; ex_redirect = 1;
    #1 chk("redirect_ctl", 32'(ctl), 32'(CtlRedir));
    tick();
    chk("redirect_flush_cnt", 32'(flush_cnt), 1);
    chk("redirect_stall_cnt", 32'(stall_cnt), 1);

    // Clear beats a stall increment in the same cycle.
    idle_inputs();
    mem_busy = 1; cnt_clr = 1;
    tick();
    chk("clr_stall_cnt", 32'(stall_cnt), 0);
    chk("clr_flush_cnt", 32'(flush_cnt), 0);

    // Halt during three busy cycles -> HALT_PEND, halted the cycle after busy drops.
    idle_inputs();
    dbg_halt_req = 1; mem_busy = 1;
    #1 chk("halt_busy_ctl", 32'(ctl), 32'(CtlHold));
    tick();
    chk("halt_pend_ctl", 32'(ctl), 32'(CtlHold));
    tick();
    tick();
    mem_busy = 0;
    #1 chk("halt_pend_release", 32'(ctl), 32'(CtlRun));
    tick();
    chk("halted", 32'(dbg_halted), 1);
    dbg_halt_req = 0; ex_redirect = 1; mem_busy = 1;
    #1 chk("frozen_with_redirect", 32'(ctl), 32'(CtlFrozen));
    chk("halt_stall_cnt", 32'(stall_cnt), 3);
    tick();
    chk("frozen_stall_cnt", 32'(stall_cnt), 3);
    chk("frozen_flush_cnt", 32'(flush_cnt), 0);

    // Step with two busy cycles: three cycles in STEP, then HALTED.
    ex_redirect = 0; dbg_step_req = 1;
    tick();
    dbg_step_req = 0;
    #1 chk("step1_ctl", 32'(ctl), 32'(CtlHold));
    tick();
    chk("step2_ctl", 32'(ctl), 32'(CtlHold));
    tick();
    mem_busy = 0;
    #1 chk("step3_ctl", 32'(ctl), 32'(CtlRun));
    tick();
    chk("step_back_halted", 32'(ctl), 32'(CtlFrozen));
    chk("step_stall_cnt", 32'(stall_cnt), 5);

    // Resume has priority over step.
    dbg_resume_req = 1; dbg_step_req = 1;
    tick();
    idle_inputs();
    #1 chk("resume_ctl", 32'(ctl), 32'(CtlRun));

    // Saturation of the stall counter.
    cnt_clr = 1;
    tick();
    cnt_clr = 0; mem_busy = 1;
    for (int i = 0; i < 65534; i++) tick();
    chk("stall_cnt_fffe", 32'(stall_cnt), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_cnt_saturate", 32'(stall_cnt), 32'h0000_FFFF);
    mem_busy = 0; cnt_clr = 1;
    tick();
    cnt_clr = 0;
    chk("stall_cnt_cleared", 32'(stall_cnt), 0);

    // Reset while halted returns to RUN.
    dbg_halt_req = 1;
    tick();
    dbg_halt_req = 0;
    chk("halted_before_rst", 32'(dbg_halted), 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    #1 chk("rst_from_halted", 32'(ctl), 32'(CtlRun));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_flow_controller.md
Name: pipeline_flow_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V core.
- Drives write-enable and flush for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the global stall line shared by all of them.
- Resolves load-use hazards, EX-stage control redirects and data-memory wait states.
- Runs a debug halt/step FSM and keeps saturating performance counters for stall and flush cycles.

Parameters:
- REG_ADDR_W, 5: register-file address width.
- CNT_W, 16: width of the stall and flush performance counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- id_rs1_addr_i  in  REG_ADDR_W  rs1 address of the instruction in ID
- id_rs2_addr_i  in  REG_ADDR_W  rs2 address of the instruction in ID
- id_uses_rs1_i  in  1  ID instruction reads rs1
- id_uses_rs2_i  in  1  ID instruction reads rs2
- ex_mem_read_i  in  1  instruction in EX is a load
- ex_rd_addr_i  in  REG_ADDR_W  destination register of the EX instruction
- ex_redirect_i  in  1  taken branch or jump resolved in EX
- mem_busy_i  in  1  data memory not ready this cycle
- dbg_halt_req_i  in  1  debug halt request (level)
- dbg_step_req_i  in  1  debug single-step request, sampled in HALTED only
- dbg_resume_req_i  in  1  debug resume request, sampled in HALTED only
- cnt_clr_i  in  1  synchronous clear of both counters
- pc_we_o  out  1  PC update enable
- if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o  out  1 each  register write enables
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  register flushes
- global_stall_o  out  1  freezes every pipeline register
- dbg_halted_o  out  1  core is halted
- stall_cnt_o  out  CNT_W  stall-cycle counter
- flush_cnt_o  out  CNT_W  redirect-flush counter

Behaviour:
- Reset, synchronous, while rst_n=0 at posedge clk:
  - FSM goes to RUN; both counters go to 0.
  - Outputs after reset: all write enables 1, pc_we_o=1, all flushes 0, global_stall_o=0, dbg_halted_o=0.
  - Reset asserted mid-halt or mid-step returns the FSM to RUN at the next edge.
- Hazard terms (combinational, same cycle as the inputs):
  - load_use = ex_mem_read_i & (ex_rd_addr_i!=0) & ((id_uses_rs1_i & rs1==rd) | (id_uses_rs2_i & rs2==rd)).
  - A register address of x0 never causes a hazard.
- Output priority, combinational from the FSM state and inputs. The first matching row applies:
  1. Frozen (FSM in HALTED): global_stall_o=1, pc_we_o=0, all write enables 0, all flushes 0. Flushes must be 0 because a flush overrides the stall inside the registers.
  2. mem_busy_i=1: pc_we_o=0, all write enables 0, all flushes 0, global_stall_o=0. The whole pipeline holds.
  3. ex_redirect_i=1: pc_we_o=1, if_id_flush_o=1, id_ex_flush_o=1, other write enables 1. A redirect overrides load_use, since the ID instruction is on the wrong path.
  4. load_use=1: pc_we_o=0, if_id_we_o=0, id_ex_flush_o=1 (inserts a bubble), ex_mem_we_o=1, mem_wb_we_o=1.
  5. Otherwise all write enables 1, pc_we_o=1, no flushes.
  - ex_mem_flush_o and mem_wb_flush_o are always 0 in this revision; they are reserved for exceptions.
- Debug FSM (registered). States RUN, HALT_PEND, HALTED, STEP:
  - RUN: if dbg_halt_req_i=1 and mem_busy_i=0, go to HALTED. If dbg_halt_req_i=1 and mem_busy_i=1, go to HALT_PEND. The request cycle itself still advances normally.
  - HALT_PEND: outputs as RUN. Go to HALTED in the first cycle with mem_busy_i=0; that cycle advances.
  - HALTED: dbg_halted_o=1. If dbg_resume_req_i=1, go to RUN. Else if dbg_step_req_i=1, go to STEP. Resume has priority over step.
  - STEP: outputs as RUN; the pipeline advances one cycle.
    - Return to HALTED after the first cycle with mem_busy_i=0.
    - While mem_busy_i=1, remain in STEP, so each step advances exactly one productive cycle.
  - dbg_halt_req_i is ignored outside RUN.
- Counters:
  - stall_cnt_o increments in non-HALTED states on cycles with (mem_busy_i | load_use) and not ex_redirect_i.
  - flush_cnt_o increments on cycles where rows 3 applies.
  - Both saturate at all-ones and do not wrap.
  - cnt_clr_i clears both, and has priority over an increment in the same cycle.

Test Plan:
- Load-use: lw x5 in EX (ex_mem_read_i=1, rd=5), ID instruction has rs2=5, uses_rs2=1 -> same cycle pc_we_o=0, if_id_we_o=0, id_ex_flush_o=1; stall_cnt_o goes 0 to 1.
- x0 and unused operand: rd=0 with rs1=0, or rd=7 with rs1=7 but id_uses_rs1_i=0 -> no stall; all write enables 1.
- Redirect with load_use: ex_redirect_i=1 together with a load-use match -> pc_we_o=1, if_id_flush_o=1, id_ex_flush_o=1; flush_cnt_o+1; stall_cnt_o unchanged.
- Halt during memory wait: dbg_halt_req_i=1 while mem_busy_i=1 for 3 cycles -> FSM in HALT_PEND; dbg_halted_o=1 one cycle after mem_busy_i drops; then global_stall_o=1 and all flushes 0, even with ex_redirect_i=1.
- Step: in HALTED, pulse dbg_step_req_i with mem_busy_i=1 for 2 cycles -> FSM in STEP for 3 cycles, back to HALTED. Asserting dbg_resume_req_i and dbg_step_req_i together -> RUN.
- Counter saturation and reset: preload stall_cnt_o to 0xFFFE and hold mem_busy_i=1 for 3 cycles -> 0xFFFF, held. cnt_clr_i -> 0. rst_n=0 while in HALTED -> RUN at the next edge with dbg_halted_o=0.
